hit_judge: RTL and testbench
============================

# hit_judge

Consumes the committed hit (timestamp, octave, note, length) produced by the key-capture stage and grades it against the expected note popped from the song stream. Emits one PERFECT/GOOD/MISS grade per expected note and maintains saturating score, combo and max-combo counters for the display/score stage. Sits directly downstream of key capture and alongside the song reader, which it pops through a valid/ready handshake.

## Interface
- CLOCK_BITS, 32, width of system_clock and all timestamps (ticks)
- OCTAVE_BITS, 2, octave width
- NOTE_BITS, 3, note index width (0..6 valid)
- LENGTH_BITS, 3, length index width (0..6 valid)
- PERFECT_WIN, 5, max |error| in ticks for PERFECT
- GOOD_WIN, 15, max |error| in ticks for GOOD; must be >= PERFECT_WIN
- PERFECT_PTS, 3, points added per PERFECT (GOOD adds 1)
- SCORE_BITS, 16 / COMBO_BITS, 10, counter widths
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  game active; rising edge starts a song, low aborts
- system_clock  in  CLOCK_BITS  current time
- hit_valid  in  1  one-cycle strobe: hit fields below valid
- hit_clock / hit_octave / hit_note / hit_length  in  CLOCK_BITS / OCTAVE_BITS / NOTE_BITS / LENGTH_BITS  committed hit
- exp_valid  in  1  song reader has an expected note
- exp_clock / exp_octave / exp_note / exp_length  in  same widths  expected note
- exp_last  in  1  expected note is final one of song
- exp_ready  out  1  one-cycle pop of current expected note
- grade_valid  out  1  one-cycle strobe with grade
- grade  out  2  0 NONE, 1 MISS, 2 GOOD, 3 PERFECT
- score  out  SCORE_BITS / combo, max_combo  out  COMBO_BITS
- done  out  1  final note graded; held until en low

## Operation
- States: IDLE, WAIT, JUDGE, ADVANCE, DONE.
- IDLE: on en rising edge clear score, combo, max_combo; go WAIT. Counters otherwise hold last values.
- WAIT: when exp_valid=0, hits dropped, no timeout. When exp_valid=1:
  - hit_valid=1: latch hit fields, go JUDGE (hit wins over a same-cycle timeout).
  - else if system_clock > exp_clock+GOOD_WIN (computed CLOCK_BITS+1 wide, no wrap): grade MISS, go ADVANCE.
- JUDGE: err = |hit_clock - exp_clock|, unsigned, CLOCK_BITS wide, larger minus smaller. match = octave and note equal.
  - hit_clock + GOOD_WIN < exp_clock (early, outside window): discard, no grade, back to WAIT.
  - match, err<=PERFECT_WIN, lengths equal: PERFECT.
  - match, err<=GOOD_WIN: GOOD.
  - otherwise MISS. Go ADVANCE.
- ADVANCE: exp_ready=1, grade_valid=1, grade driven. PERFECT adds PERFECT_PTS, GOOD adds 1, both saturate at all-ones; GOOD/PERFECT increment combo (saturating), MISS clears combo; max_combo = max(max_combo, new combo). exp_last=1 -> DONE, else WAIT.
- DONE: done=1; en low -> IDLE.
- en low in any non-IDLE state: IDLE next cycle, no pop, no grade, counters hold.
- hit_valid outside WAIT: ignored.

## Timing
- Reset: state IDLE; exp_ready, grade_valid, done = 0; grade = NONE; score, combo, max_combo = 0.
- All outputs registered. hit_valid in cycle N -> grade_valid/exp_ready in N+2; counters updated in N+3.
- Timeout detected cycle N -> grade_valid/exp_ready in N+1.
- exp_ready high exactly one cycle per graded note; song reader presents next note from following cycle; fields sampled only in WAIT/JUDGE.
- grade holds its value between strobes; grade_valid alone qualifies it.

## Structure
- Constants.vh: width constants (shared with key capture), GRADE_NONE/MISS/GOOD/PERFECT encodings, state encodings.
- Existing Pulse sub-module reused for en rising-edge detect.
- One combinational sub-module natural: judge_window (err, match, early flag -> grade).

## Test plan
- exp {clock 1000, oct 1, note 3, len 2}, hit {1003,1,3,2} -> PERFECT at N+2, score 3, combo 1.
- Same exp, hit {1012,1,3,2} -> GOOD, score +1; hit {1004,1,4,2} -> MISS, combo 0, max_combo retained.
- No hit, system_clock advances to 1016 -> MISS one cycle later, exp_ready pulse; at 1015 no MISS.
- Hit {980,...} for exp 1000 -> discarded, no grade_valid; then hit {998,...} -> PERFECT.
- hit_valid and timeout same cycle -> hit judged; exp_last=1 note graded -> done=1 until en low; en low mid-JUDGE -> IDLE, no pop.
- Score saturation: PERFECT_PTS hits from score 65534 -> 65535; rst_n low mid-song -> all outputs reset immediately.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// hit_judge shared constants: default widths, grade codes, FSM states.
package hit_judge_pkg;

  localparam int CLOCK_W = 32;
  localparam int OCT_W   = 2;
  localparam int NOTE_W  = 3;
  localparam int LEN_W   = 3;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_MISS    = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_JUDGE,
    S_ADVANCE,
    S_DONE
  } state_e;

endpackage

// File: rtl/hit_judge_window.sv
// Timing-window classifier: hit vs expected note -> early flag and grade.
module hit_judge_window
  import hit_judge_pkg::*;
#(
  parameter int CLOCK_BITS  = CLOCK_W,
  parameter int OCTAVE_BITS = OCT_W,
  parameter int NOTE_BITS   = NOTE_W,
  parameter int LENGTH_BITS = LEN_W,
  parameter int PERFECT_WIN = 5,
  parameter int GOOD_WIN    = 15
) (
  input  logic [CLOCK_BITS-1:0]  hit_clock,
  input  logic [OCTAVE_BITS-1:0] hit_octave,
  input  logic [NOTE_BITS-1:0]   hit_note,
  input  logic [LENGTH_BITS-1:0] hit_length,
  input  logic [CLOCK_BITS-1:0]  exp_clock,
  input  logic [OCTAVE_BITS-1:0] exp_octave,
  input  logic [NOTE_BITS-1:0]   exp_note,
  input  logic [LENGTH_BITS-1:0] exp_length,
  output logic                   early,
  output grade_e                 grade
);

  logic [CLOCK_BITS-1:0] err;
  logic [CLOCK_BITS:0]   hit_late;
  logic                  match;
  logic                  same_len;

  always_comb begin
    err = (hit_clock >= exp_clock)
        ? hit_clock - exp_clock
        : exp_clock - hit_clock;
    // one extra bit so the window edge never wraps
    hit_late = {1'b0, hit_clock}
             + (CLOCK_BITS+1)'(GOOD_WIN);
    early = hit_late < {1'b0, exp_clock};
    match = (hit_octave == exp_octave)
         && (hit_note == exp_note);
    same_len = hit_length == exp_length;
    grade = GRADE_MISS;
    if (match && same_len
        && err <= CLOCK_BITS'(PERFECT_WIN))
      grade = GRADE_PERFECT;
    else if (match
        && err <= CLOCK_BITS'(GOOD_WIN))
      grade = GRADE_GOOD;
  end

endmodule

// File: rtl/hit_judge.sv
// Grades committed hits against the song stream and keeps
// saturating score / combo / max-combo counters.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int CLOCK_BITS  = CLOCK_W,
  parameter int OCTAVE_BITS = OCT_W,
  parameter int NOTE_BITS   = NOTE_W,
  parameter int LENGTH_BITS = LEN_W,
  parameter int PERFECT_WIN = 5,
  parameter int GOOD_WIN    = 15,
  parameter int PERFECT_PTS = 3,
  parameter int SCORE_BITS  = 16,
  parameter int COMBO_BITS  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [CLOCK_BITS-1:0]  system_clock,
  input  logic                   hit_valid,
  input  logic [CLOCK_BITS-1:0]  hit_clock,
  input  logic [OCTAVE_BITS-1:0] hit_octave,
  input  logic [NOTE_BITS-1:0]   hit_note,
  input  logic [LENGTH_BITS-1:0] hit_length,
  input  logic                   exp_valid,
  input  logic [CLOCK_BITS-1:0]  exp_clock,
  input  logic [OCTAVE_BITS-1:0] exp_octave,
  input  logic [NOTE_BITS-1:0]   exp_note,
  input  logic [LENGTH_BITS-1:0] exp_length,
  input  logic                   exp_last,
  output logic                   exp_ready,
  output logic                   grade_valid,
  output logic [1:0]             grade,
  output logic [SCORE_BITS-1:0]  score,
  output logic [COMBO_BITS-1:0]  combo,
  output logic [COMBO_BITS-1:0]  max_combo,
  output logic                   done
);

  state_e state, state_n;

  logic                   en_q, en_rise;
  logic [CLOCK_BITS-1:0]  hclk_q;
  logic [OCTAVE_BITS-1:0] hoct_q;
  logic [NOTE_BITS-1:0]   hnote_q;
  logic [LENGTH_BITS-1:0] hlen_q;
  logic                   last_q, last_n;
  logic                   latch;
  logic                   timeout;
  logic                   early;
  grade_e                 jgrade;

  logic                  ready_n, valid_n, done_n;
  logic [1:0]            grade_n;
  logic [SCORE_BITS-1:0] score_n, pts;
  logic [SCORE_BITS:0]   score_sum;
  logic [COMBO_BITS-1:0] combo_n, max_n;

  assign en_rise = en & ~en_q;
  assign timeout = {1'b0, system_clock}
                 > {1'b0, exp_clock}
                 + (CLOCK_BITS+1)'(GOOD_WIN);

  hit_judge_window #(
    .CLOCK_BITS  (CLOCK_BITS),
    .OCTAVE_BITS (OCTAVE_BITS),
    .NOTE_BITS   (NOTE_BITS),
    .LENGTH_BITS (LENGTH_BITS),
    .PERFECT_WIN (PERFECT_WIN),
    .GOOD_WIN    (GOOD_WIN)
  ) u_window (
    .hit_clock  (hclk_q),
    .hit_octave (hoct_q),
    .hit_note   (hnote_q),
    .hit_length (hlen_q),
    .exp_clock  (exp_clock),
    .exp_octave (exp_octave),
    .exp_note   (exp_note),
    .exp_length (exp_length),
    .early      (early),
    .grade      (jgrade)
  );

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    last_n  = last_q;
    grade_n = grade;
    score_n = score;
    combo_n = combo;
    max_n   = max_combo;
    pts = (grade == GRADE_PERFECT)
        ? SCORE_BITS'(PERFECT_PTS)
        : (grade == GRADE_GOOD)
        ? SCORE_BITS'(1) : '0;
    score_sum = {1'b0, score} + {1'b0, pts};
    unique case (state)
      S_IDLE: if (en_rise) begin
        score_n = '0;
        combo_n = '0;
        max_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: if (exp_valid) begin
        if (hit_valid) begin
          latch   = 1'b1;
          state_n = S_JUDGE;
        end else if (timeout) begin
          grade_n = GRADE_MISS;
          last_n  = exp_last;
          state_n = S_ADVANCE;
        end
      end
      S_JUDGE: if (early) begin
        state_n = S_WAIT;
      end else begin
        grade_n = jgrade;
        last_n  = exp_last;
        state_n = S_ADVANCE;
      end
      S_ADVANCE: begin
        score_n = score_sum[SCORE_BITS]
                ? '1 : score_sum[SCORE_BITS-1:0];
        if (grade == GRADE_MISS)
          combo_n = '0;
        else
          combo_n = (&combo) ? combo
                  : combo + 1'b1;
        max_n = (combo_n > max_combo)
              ? combo_n : max_combo;
        state_n = last_q ? S_DONE : S_WAIT;
      end
      S_DONE: ;
      default: state_n = S_IDLE;
    endcase
    // abort: drop everything in flight
    if (state != S_IDLE && !en) begin
      state_n = S_IDLE;
      latch   = 1'b0;
      grade_n = grade;
      score_n = score;
      combo_n = combo;
      max_n   = max_combo;
    end
    ready_n = state_n == S_ADVANCE;
    valid_n = state_n == S_ADVANCE;
    done_n  = state_n == S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
      exp_ready   <= 1'b0;
      grade_valid <= 1'b0;
      grade       <= GRADE_NONE;
      done        <= 1'b0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      state       <= state_n;
      en_q        <= en;
      last_q      <= last_n;
      exp_ready   <= ready_n;
      grade_valid <= valid_n;
      grade       <= grade_n;
      done        <= done_n;
      score       <= score_n;
      combo       <= combo_n;
      max_combo   <= max_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hclk_q  <= '0;
      hoct_q  <= '0;
      hnote_q <= '0;
      hlen_q  <= '0;
    end else if (latch) begin
      hclk_q  <= hit_clock;
      hoct_q  <= hit_octave;
      hnote_q <= hit_note;
      hlen_q  <= hit_length;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: directed edge cases plus random notes.
module tb_hit_judge;
  import hit_judge_pkg::*;

  // narrow counters so saturation is reachable quickly
  localparam int SB = 8;
  localparam int CB = 4;
  localparam int SMAX = (1 << SB) - 1;
  localparam int CMAX = (1 << CB) - 1;
  localparam int PW = 5;
  localparam int GW = 15;
  localparam int PP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [31:0] system_clock = '0;
  logic hit_valid = 1'b0;
  logic [31:0] hit_clock = '0;
  logic [1:0] hit_octave = '0;
  logic [2:0] hit_note = '0;
  logic [2:0] hit_length = '0;
  logic exp_valid = 1'b0;
  logic [31:0] exp_clock = '0;
  logic [1:0] exp_octave = '0;
  logic [2:0] exp_note = '0;
  logic [2:0] exp_length = '0;
  logic exp_last = 1'b0;
  logic exp_ready, grade_valid, done;
  logic [1:0] grade;
  logic [SB-1:0] score;
  logic [CB-1:0] combo, max_combo;

  always #5 clk = ~clk;

  hit_judge #(.SCORE_BITS(SB), .COMBO_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .system_clock(system_clock),
    .hit_valid(hit_valid), .hit_clock(hit_clock),
    .hit_octave(hit_octave), .hit_note(hit_note),
    .hit_length(hit_length),
    .exp_valid(exp_valid), .exp_clock(exp_clock),
    .exp_octave(exp_octave), .exp_note(exp_note),
    .exp_length(exp_length), .exp_last(exp_last),
    .exp_ready(exp_ready), .grade_valid(grade_valid),
    .grade(grade), .score(score), .combo(combo),
    .max_combo(max_combo), .done(done)
  );

  typedef struct {
    int g; int cyc; int sc; int cb; int mx;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit pend = 0;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int m_score = 0, m_combo = 0, m_max = 0;
  int e_clk, e_oct, e_note, e_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input longint act,
                     input longint want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grade(int hc, int ho,
                                     int hn, int hl);
    int d = hc - e_clk;
    int ad = (d < 0) ? -d : d;
    bit m = (ho == e_oct) && (hn == e_note);
    if (d < -GW) return 0;
    if (m && ad <= PW && hl == e_len) return 3;
    if (m && ad <= GW) return 2;
    return 1;
  endfunction

  task automatic push(int g, int at);
    exp_t e;
    if (g == 3)
      m_score = (m_score + PP > SMAX) ? SMAX : m_score + PP;
    else if (g == 2)
      m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
    if (g >= 2)
      m_combo = (m_combo == CMAX) ? CMAX : m_combo + 1;
    else
      m_combo = 0;
    if (m_combo > m_max) m_max = m_combo;
    e = '{g, at, m_score, m_combo, m_max};
    q.push_back(e);
  endtask

  task automatic clear_model();
    m_score = 0;
    m_combo = 0;
    m_max = 0;
  endtask

  task automatic set_exp(int c, int o, int n,
                         int l, bit last);
    e_clk = c; e_oct = o; e_note = n; e_len = l;
    exp_valid = 1'b1;
    exp_clock = 32'(c);
    exp_octave = 2'(o);
    exp_note = 3'(n);
    exp_length = 3'(l);
    exp_last = last;
    system_clock = 32'(c - 100);
  endtask

  task automatic wait_pop(input string name);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = exp_ready;
    end
    chk({name, "_pop"}, seen, 1);
    tick();
  endtask

  task automatic do_hit(int hc, int ho, int hn,
                        int hl, bit extra);
    int g = model_grade(hc, ho, hn, hl);
    hit_valid = 1'b1;
    hit_clock = 32'(hc);
    hit_octave = 2'(ho);
    hit_note = 3'(hn);
    hit_length = 3'(hl);
    if (g != 0) push(g, cyc + 2);
    tick();
    if (extra) begin
      hit_clock = 32'(hc + 40);
      hit_note = 3'(hn + 1);
    end else hit_valid = 1'b0;
    @(negedge clk);
    hit_valid = 1'b0;
    if (g != 0) wait_pop("hit");
    else tick();
  endtask

  task automatic do_timeout();
    system_clock = 32'(e_clk + GW);
    repeat (3) tick();
    system_clock = 32'(e_clk + GW + 1);
    push(1, cyc + 1);
    wait_pop("timeout");
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("score", score, cur.sc);
      chk("combo", combo, cur.cb);
      chk("max_combo", max_combo, cur.mx);
      pend = 0;
    end
    if (grade_valid || exp_ready) begin
      chk("ready_vs_valid", exp_ready, grade_valid);
      if (q.size() == 0) begin
        chk("unexpected_grade", grade_valid, 0);
      end else begin
        cur = q.pop_front();
        chk("grade", grade, cur.g);
        chk("latency", cyc, cur.cyc);
        pend = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, o, n, l, off, ho, hn, hl;
    tick();
    @(negedge clk);
    chk("rst_ready", exp_ready, 0);
    chk("rst_valid", grade_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_grade", grade, 0);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    tick();

    set_exp(1000, 1, 3, 2, 0);
    do_hit(1003, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(1012, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(1004, 1, 4, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_timeout();
    set_exp(1000, 1, 3, 2, 0);
    do_hit(980, 1, 3, 2, 0);
    do_hit(998, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(1015, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(1016, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(984, 1, 3, 2, 0);
    do_hit(985, 1, 3, 2, 0);
    set_exp(1000, 1, 3, 2, 0);
    do_hit(1005, 1, 3, 2, 1);
    // hit and timeout in the same cycle
    set_exp(1000, 1, 3, 2, 0);
    system_clock = 32'd1030;
    do_hit(1003, 1, 3, 2, 0);

    // no expected note: hits dropped, no timeout
    exp_valid = 1'b0;
    system_clock = 32'd9000;
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 90; i++) begin
      set_exp(2000 + i * 50, 2, 5, 1, 0);
      do_hit(2005 + i * 50, 2, 5, 1, (i % 7) == 0);
    end

    // abort while judging
    set_exp(3000, 0, 1, 1, 0);
    hit_valid = 1'b1;
    hit_clock = 32'd3000;
    hit_octave = 2'd0;
    hit_note = 3'd1;
    hit_length = 3'd1;
    tick();
    hit_valid = 1'b0;
    en = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("abort_hold_score", score, m_score);
    chk("abort_hold_max", max_combo, m_max);
    tick();
    en = 1'b1;
    clear_model();
    tick();
    @(negedge clk);
    chk("restart_score", score, 0);
    chk("restart_max", max_combo, 0);
    tick();

    for (int i = 0; i < 150; i++) begin
      c = 10000 + i * 200;
      o = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 6));
      l = int'($urandom_range(0, 6));
      set_exp(c, o, n, l, 0);
      if ($urandom_range(0, 9) < 2) begin
        do_timeout();
      end else begin
        off = int'($urandom_range(0, 64)) - 32;
        ho = ($urandom_range(0, 3) == 0) ? (o ^ 1) : o;
        hn = ($urandom_range(0, 3) == 0) ? (n + 1) % 7 : n;
        hl = ($urandom_range(0, 2) == 0) ? (l + 1) % 7 : l;
        if (model_grade(c + off, ho, hn, hl) == 0) begin
          do_hit(c + off, ho, hn, hl, $urandom_range(0, 3) == 0);
          off = int'($urandom_range(0, 30)) - 15;
          do_hit(c + off, o, n, l, 0);
        end else begin
          do_hit(c + off, ho, hn, hl, $urandom_range(0, 3) == 0);
        end
      end
    end

    // final note of the song
    set_exp(50000, 0, 0, 0, 1);
    do_hit(50000, 0, 0, 0, 0);
    exp_valid = 1'b0;
    @(negedge clk);
    chk("done_set", done, 1);
    tick();
    tick();
    @(negedge clk);
    chk("done_held", done, 1);
    tick();
    en = 1'b0;
    tick();
    @(negedge clk);
    chk("done_clear", done, 0);
    tick();
    en = 1'b1;
    clear_model();
    tick();

    // asynchronous reset mid-song
    set_exp(60000, 3, 6, 6, 0);
    do_hit(60002, 3, 6, 6, 0);
    set_exp(60000, 3, 6, 6, 0);
    hit_valid = 1'b1;
    hit_clock = 32'd60000;
    hit_octave = 2'd3;
    hit_note = 3'd6;
    hit_length = 3'd6;
    tick();
    hit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_combo", combo, 0);
    chk("arst_max", max_combo, 0);
    chk("arst_grade", grade, 0);
    chk("arst_ready", exp_ready, 0);
    chk("arst_done", done, 0);
    tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    tick();
    set_exp(61000, 1, 1, 1, 0);
    do_hit(60999, 1, 1, 1, 0);
    exp_valid = 1'b0;
    repeat (4) tick();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
